// File: rtl/systolic_sequencer.sv
// systolic_sequencer
//   Sequences one inference pass of the systolic array. A start request
//   latches the array configuration. The block then streams activation-buffer
//   read addresses and waits for the array pipeline to drain. It finishes with
//   a one-cycle done pulse. Weight-buffer swaps happen only while no
//   activations are in flight. A swap request that arrives during a pass is
//   held and serviced after that pass completes.
//
// Ports
//   clk            clock
//   resetn         synchronous, active-low reset
//   start          one-cycle start request
//   weight_req     one-cycle weight transfer request
//   cfg_last_row   last active row index
//   cfg_last_col   last active column index
//   cfg_addr_start first activation address
//   cfg_batch      number of activation vectors
//   act_rd_en      activation buffer read enable
//   act_rd_addr    activation buffer read address
//   weight_swap    one-cycle pulse: copy buffered weights into the array
//   busy           high from the first cycle after accept through DONE
//   done           one-cycle completion pulse
//   start_err      one-cycle pulse: start dropped because busy
module systolic_sequencer #(
  parameter int ADDR_W  = 11,
  parameter int DIM_W   = 5,
  parameter int BATCH_W = 6,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               weight_req,
  input  logic [DIM_W-1:0]   cfg_last_row,
  input  logic [DIM_W-1:0]   cfg_last_col,
  input  logic [ADDR_W-1:0]  cfg_addr_start,
  input  logic [BATCH_W-1:0] cfg_batch,
  output logic               act_rd_en,
  output logic [ADDR_W-1:0]  act_rd_addr,
  output logic               weight_swap,
  output logic               busy,
  output logic               done,
  output logic               start_err
);

  typedef enum logic [2:0] {IDLE, SWAP, FEED, DRAIN, DONE} state_t;

  state_t             state;
  logic               start_pend;
  logic               weight_pend;
  logic [DIM_W-1:0]   lat_last_row;
  logic [DIM_W-1:0]   lat_last_col;
  logic [ADDR_W-1:0]  lat_addr_start;
  logic [BATCH_W-1:0] lat_batch;
  // Reads still to issue after the current FEED cycle.
  logic [BATCH_W-1:0] feed_cnt;
  // DRAIN cycles still to wait after the current one.
  logic [DIM_W+1:0]   drain_cnt;
  logic [DIM_W+1:0]   drain_init;

  // The drain lasts last_row+last_col+RD_LAT+1 cycles. The counter is loaded
  // with one less than that because the entry cycle is itself a drain cycle.
  assign drain_init = {2'b00, lat_last_row} + {2'b00, lat_last_col}
                    + (DIM_W+2)'(RD_LAT);

  // Outputs are registered. Each transition sets the output values that the
  // state being entered must present.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      start_pend     <= 1'b0;
      weight_pend    <= 1'b0;
      lat_last_row   <= '0;
      lat_last_col   <= '0;
      lat_addr_start <= '0;
      lat_batch      <= '0;
      feed_cnt       <= '0;
      drain_cnt      <= '0;
      act_rd_en      <= 1'b0;
      act_rd_addr    <= '0;
      weight_swap    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      start_err      <= 1'b0;
    end else begin
      weight_swap <= 1'b0;
      done        <= 1'b0;
      start_err   <= 1'b0;
      act_rd_en   <= 1'b0;

      if (start && state != IDLE) start_err <= 1'b1;
      // Requests outside IDLE collapse into one pending swap.
      if (weight_req && state != IDLE) weight_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            lat_last_row   <= cfg_last_row;
            lat_last_col   <= cfg_last_col;
            lat_addr_start <= cfg_addr_start;
            lat_batch      <= cfg_batch;
          end
          if (weight_req || weight_pend) begin
            // The swap goes first, so the new weights are in place before
            // any activation of this pass is read.
            state       <= SWAP;
            weight_pend <= 1'b0;
            weight_swap <= 1'b1;
            start_pend  <= start;
            busy        <= start;
          end else if (start) begin
            busy <= 1'b1;
            if (cfg_batch == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FEED;
              act_rd_en   <= 1'b1;
              act_rd_addr <= cfg_addr_start;
              feed_cnt    <= cfg_batch - BATCH_W'(1);
            end
          end
        end

        SWAP: begin
          start_pend <= 1'b0;
          if (start_pend) begin
            if (lat_batch == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state       <= FEED;
              act_rd_en   <= 1'b1;
              act_rd_addr <= lat_addr_start;
              feed_cnt    <= lat_batch - BATCH_W'(1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        FEED: begin
          if (feed_cnt != '0) begin
            act_rd_en   <= 1'b1;
            act_rd_addr <= act_rd_addr + ADDR_W'(1);
            feed_cnt    <= feed_cnt - BATCH_W'(1);
          end else begin
            state     <= DRAIN;
            drain_cnt <= drain_init;
          end
        end

        DRAIN: begin
          if (drain_cnt != '0) begin
            drain_cnt <= drain_cnt - (DIM_W+2)'(1);
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          busy <= 1'b0;
          if (weight_pend || weight_req) begin
            state       <= SWAP;
            weight_swap <= 1'b1;
            weight_pend <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;
  localparam int ADDR_W  = 11;
  localparam int DIM_W   = 5;
  localparam int BATCH_W = 6;
  localparam int RD_LAT  = 1;
  localparam int NB      = 512;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               start = 1'b0;
  logic               weight_req = 1'b0;
  logic [DIM_W-1:0]   cfg_last_row = '0;
  logic [DIM_W-1:0]   cfg_last_col = '0;
  logic [ADDR_W-1:0]  cfg_addr_start = '0;
  logic [BATCH_W-1:0] cfg_batch = '0;
  logic               act_rd_en;
  logic [ADDR_W-1:0]  act_rd_addr;
  logic               weight_swap;
  logic               busy;
  logic               done;
  logic               start_err;

  systolic_sequencer #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .BATCH_W(BATCH_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .weight_req(weight_req),
    .cfg_last_row(cfg_last_row), .cfg_last_col(cfg_last_col),
    .cfg_addr_start(cfg_addr_start), .cfg_batch(cfg_batch),
    .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
    .weight_swap(weight_swap), .busy(busy), .done(done), .start_err(start_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              swap;
    logic              busy;
    logic              done;
    logic              err;
  } exp_t;

  exp_t ex [NB];
  exp_t tr [NB];

  int cyc = 0;
  bit chk_en = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Model: the cycle from which the sequencer is idle, the cycle in which it
  // presents done, and the collapsed pending weight request.
  int free_at = 0;
  int done_at = -1;
  bit pend = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, want);
    end
  endtask

  // Lays out a whole pass from cycle r onward, using the cfg values that
  // are current at acceptance.
  task automatic sched_run(input int r);
    int b;
    int d;
    int k;
    b = int'(cfg_batch);
    d = int'(cfg_last_row) + int'(cfg_last_col) + RD_LAT + 1;
    for (int i = 0; i < b; i++) begin
      ex[(r+i)%NB].en   = 1'b1;
      ex[(r+i)%NB].addr = ADDR_W'((int'(cfg_addr_start) + i) % (1 << ADDR_W));
      ex[(r+i)%NB].busy = 1'b1;
    end
    if (b == 0) k = r;
    else begin
      for (int j = 0; j < d; j++) ex[(r+b+j)%NB].busy = 1'b1;
      k = r + b + d;
    end
    ex[k%NB].done = 1'b1;
    ex[k%NB].busy = 1'b1;
    done_at = k;
    free_at = k + 1;
  endtask

  task automatic model_step(input int c, input bit rn, input bit st, input bit wr);
    if (!rn) begin
      for (int j = 1; j < 300; j++) ex[(c+j)%NB] = '0;
      free_at = c + 1;
      done_at = -1;
      pend = 0;
    end else if (c == done_at) begin
      if (st) ex[(c+1)%NB].err = 1'b1;
      if (pend || wr) begin
        ex[(c+1)%NB].swap = 1'b1;
        free_at = c + 2;
        pend = 0;
      end
      done_at = -1;
    end else if (c >= free_at) begin
      if (st) begin
        if (pend || wr) begin
          ex[(c+1)%NB].swap = 1'b1;
          ex[(c+1)%NB].busy = 1'b1;
          pend = 0;
          sched_run(c + 2);
        end else begin
          sched_run(c + 1);
        end
      end else if (pend || wr) begin
        ex[(c+1)%NB].swap = 1'b1;
        free_at = c + 2;
        pend = 0;
      end
    end else begin
      if (st) ex[(c+1)%NB].err = 1'b1;
      if (wr) pend = 1;
    end
  endtask

  task automatic step(input bit rn, input bit st, input bit wr);
    resetn = rn;
    start = st;
    weight_req = wr;
    model_step(cyc, rn, st, wr);
    @(posedge clk);
    cyc++;
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_cfg(input int a, input int b, input int lr, input int lc);
    cfg_addr_start = ADDR_W'(a);
    cfg_batch      = BATCH_W'(b);
    cfg_last_row   = DIM_W'(lr);
    cfg_last_col   = DIM_W'(lc);
  endtask

  function automatic int count_swap(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(tr[i%NB].swap);
    return n;
  endfunction

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(tr[i%NB].done);
    return n;
  endfunction

  function automatic int count_en(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) n += int'(tr[i%NB].en);
    return n;
  endfunction

  // Per-cycle comparison against the model, plus a trace for literal checks.
  always @(negedge clk) begin
    if (chk_en) begin
      int s;
      s = cyc % NB;
      check("act_rd_en", 32'(act_rd_en), 32'(ex[s].en));
      if (ex[s].en) check("act_rd_addr", 32'(act_rd_addr), 32'(ex[s].addr));
      check("weight_swap", 32'(weight_swap), 32'(ex[s].swap));
      check("busy", 32'(busy), 32'(ex[s].busy));
      check("done", 32'(done), 32'(ex[s].done));
      check("start_err", 32'(start_err), 32'(ex[s].err));
      tr[s].en   = act_rd_en;
      tr[s].addr = act_rd_addr;
      tr[s].swap = weight_swap;
      tr[s].busy = busy;
      tr[s].done = done;
      tr[s].err  = start_err;
      ex[s] = '0;
    end
  end

  initial begin
    int s;
    for (int i = 0; i < NB; i++) begin
      ex[i] = '0;
      tr[i] = '0;
    end

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_addr", 32'(act_rd_addr), 32'd0);
    idle(2);

    // Basic run
    set_cfg('h010, 3, 1, 1);
    s = cyc;
    step(1'b1, 1'b1, 1'b0);
    idle(10);
    check("t1_addr_c1", 32'(tr[(s+1)%NB].addr), 32'h010);
    check("t1_addr_c3", 32'(tr[(s+3)%NB].addr), 32'h012);
    check("t1_en_c4", 32'(tr[(s+4)%NB].en), 32'd0);
    check("t1_busy_c4", 32'(tr[(s+4)%NB].busy), 32'd1);
    check("t1_done_c8", 32'(tr[(s+8)%NB].done), 32'd1);
    check("t1_busy_c9", 32'(tr[(s+9)%NB].busy), 32'd0);

    // Address wrap
    set_cfg('h7FE, 4, 2, 3);
    s = cyc;
    step(1'b1, 1'b1, 1'b0);
    idle(14);
    check("t2_addr_c2", 32'(tr[(s+2)%NB].addr), 32'h7FF);
    check("t2_addr_c3", 32'(tr[(s+3)%NB].addr), 32'h000);
    check("t2_done_c12", 32'(tr[(s+12)%NB].done), 32'd1);
    check("t2_done_c11", 32'(tr[(s+11)%NB].done), 32'd0);

    // Simultaneous start and weight request
    set_cfg('h100, 2, 0, 0);
    s = cyc;
    step(1'b1, 1'b1, 1'b1);
    idle(10);
    check("t3_swap_c1", 32'(tr[(s+1)%NB].swap), 32'd1);
    check("t3_en_c2", 32'(tr[(s+2)%NB].en), 32'd1);
    check("t3_done_c6", 32'(tr[(s+6)%NB].done), 32'd1);
    check("t3_swaps", 32'(count_swap(s+1, s+10)), 32'd1);

    // Weight requests during FEED are held until after done
    set_cfg('h020, 5, 0, 0);
    s = cyc;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle(10);
    check("t4_noswap", 32'(count_swap(s+1, s+8)), 32'd0);
    check("t4_done_c8", 32'(tr[(s+8)%NB].done), 32'd1);
    check("t4_swap_c9", 32'(tr[(s+9)%NB].swap), 32'd1);
    check("t4_busy_c9", 32'(tr[(s+9)%NB].busy), 32'd0);
    check("t4_swaps", 32'(count_swap(s+1, s+14)), 32'd1);

    // Start during DRAIN is rejected
    set_cfg('h030, 2, 0, 0);
    s = cyc;
    step(1'b1, 1'b1, 1'b0);
    idle(2);
    set_cfg('h555, 9, 7, 7);
    step(1'b1, 1'b1, 1'b0);
    idle(12);
    check("t5_err_c4", 32'(tr[(s+4)%NB].err), 32'd1);
    check("t5_done_c5", 32'(tr[(s+5)%NB].done), 32'd1);
    check("t5_norerun", 32'(count_en(s+6, s+15)), 32'd0);

    // Zero batch
    set_cfg('h040, 0, 3, 3);
    s = cyc;
    step(1'b1, 1'b1, 1'b0);
    idle(4);
    check("t6_done_c1", 32'(tr[(s+1)%NB].done), 32'd1);
    check("t6_noread", 32'(count_en(s+1, s+4)), 32'd0);

    // Reset in the middle of FEED
    set_cfg('h050, 10, 2, 2);
    s = cyc;
    step(1'b1, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 1'b0, 1'b0);
    idle(25);
    check("t7_en_rst", 32'(tr[(s+4)%NB].en), 32'd0);
    check("t7_busy_rst", 32'(tr[(s+4)%NB].busy), 32'd0);
    check("t7_nodone", 32'(count_done(s+4, s+28)), 32'd0);
    set_cfg('h060, 1, 0, 0);
    s = cyc;
    step(1'b1, 1'b1, 1'b0);
    idle(6);
    check("t7_rerun_addr", 32'(tr[(s+1)%NB].addr), 32'h060);
    check("t7_rerun_done", 32'(tr[(s+4)%NB].done), 32'd1);

    // Randomized traffic; cfg changes every cycle to exercise latching
    for (int i = 0; i < 4000; i++) begin
      int b;
      b = ($urandom % 8 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      set_cfg(int'($urandom % 2048), b, int'($urandom % 32), int'($urandom % 32));
      step(($urandom % 400) != 0, ($urandom % 10) == 0, ($urandom % 14) == 0);
    end
    idle(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
